// File: rtl/button_led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : button_led_ctrl_pkg
//  Purpose  : Shared constants for the button-to-LED controller slice.
//  Revision : 1.0  initial release
// ============================================================================
package button_led_ctrl_pkg;

  // Per-channel LED source select
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  // Counter width for a debounce window of db_cycles samples; never below 1 bit
  function automatic int db_cnt_width(input int db_cycles);
    return (db_cycles > 1) ? $clog2(db_cycles) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : One-channel button conditioner: 2-flop synchroniser, debounce
//             counter, stable level and one-cycle press pulse.
//  Revision : 1.0  initial release
// ============================================================================
module btn_debounce
  import button_led_ctrl_pkg::*;
#(
  parameter int DB_CYCLES   = 120000,
  parameter bit BUT_ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic but,
  output logic pressed,
  output logic press_p
);

  localparam int              c_cw       = db_cnt_width(DB_CYCLES);
  localparam logic [c_cw-1:0] c_cnt_max  = c_cw'(DB_CYCLES - 1);
  localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
  // Raw pin level of a released button, so reset does not look like a press
  localparam logic            c_idle_raw = BUT_ACT_LOW;

  logic            r_sync1;
  logic            r_sync2;
  logic [c_cw-1:0] r_cnt;
  logic            r_stable;
  logic            r_stable_d;
  logic            r_press_p;
  logic            w_lv;

  // Logical level: 1 means pressed regardless of pin polarity
  assign w_lv = r_sync2 ^ BUT_ACT_LOW;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= c_idle_raw;
      r_sync2 <= c_idle_raw;
    end else begin
      r_sync1 <= but;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (w_lv == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_max) begin
      r_stable <= w_lv;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  // Rising-edge detect on the stable level; releases produce no pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stable_d <= 1'b0;
      r_press_p  <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_press_p  <= r_stable & ~r_stable_d;
    end
  end

  assign pressed = r_stable;
  assign press_p = r_press_p;

endmodule
`default_nettype wire

// File: rtl/button_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : button_led_ctrl
//  Purpose  : N-channel button-to-LED controller. Each button is debounced;
//             each LED follows either the debounced level or a toggle bit.
//  Revision : 1.0  initial release
// ============================================================================
module button_led_ctrl
  import button_led_ctrl_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int DB_CYCLES   = 120000,
  parameter bit BUT_ACT_LOW = 1'b1,
  parameter bit LED_ACT_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] but,
  input  logic [NCH-1:0] mode,
  output logic [NCH-1:0] led,
  output logic [NCH-1:0] pressed,
  output logic [NCH-1:0] press_p
);

  localparam logic [NCH-1:0] c_led_inv = {NCH{LED_ACT_LOW}};

  logic [NCH-1:0] w_stable;
  logic [NCH-1:0] w_press_p;
  logic [NCH-1:0] w_led_int;
  logic [NCH-1:0] r_tog;
  logic [NCH-1:0] r_led;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      btn_debounce #(
        .DB_CYCLES   (DB_CYCLES),
        .BUT_ACT_LOW (BUT_ACT_LOW)
      ) u_db (
        .clk     (clk),
        .rstn    (rstn),
        .but     (but[gi]),
        .pressed (w_stable[gi]),
        .press_p (w_press_p[gi])
      );
    end
  endgenerate

  // Toggle state flips on every accepted press, whatever the current mode
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tog <= '0;
    end else begin
      r_tog <= r_tog ^ w_press_p;
    end
  end

  // Per-channel LED source select
  always_comb begin
    w_led_int = '0;
    for (int i = 0; i < NCH; i++) begin
      w_led_int[i] = (mode[i] == MODE_TOGGLE) ? r_tog[i] : w_stable[i];
    end
  end

  // Registered LED drive with pin polarity applied
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_led <= c_led_inv;
    end else begin
      r_led <= w_led_int ^ c_led_inv;
    end
  end

  assign led     = r_led;
  assign pressed = w_stable;
  assign press_p = w_press_p;

endmodule
`default_nettype wire
